// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract sequencer around a single full-adder cell

module FA (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum,
    output logic carry
);
    assign sum   = a_in ^ b_in ^ c_in;
    assign carry = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             ovf_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_shift;

    FA u_fa (
        .a_in  (a_q[0]),
        .b_in  (b_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign res_shift = {fa_sum, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_in) begin
                    // Subtract is A + ~B + 1, so the carry seeds the +1
                    a_d     = a_in;
                    b_d     = sub_in ? ~b_in : b_in;
                    carry_d = sub_in ? 1'b1 : c_in;
                    sub_d   = sub_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_MSB_IN) begin
                    cmsb_d = fa_carry;
                end
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_shift;
                    cout_d  = fa_carry;
                    ovf_d   = cmsb_q ^ fa_carry;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Mode bit is kept for observability; borrow sense needs no special handling
    logic unused_mode;
    assign unused_mode = sub_q;

    assign ready_out = (state_q == IDLE) || (state_q == DONE);
    assign busy_out  = (state_q == RUN);
    assign done_out  = (state_q == DONE);
    assign sum_out   = sum_q;
    assign carry_out = cout_q;
    assign ovf_out   = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed and model-checked bench for serial_adder_ctrl

module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 0, sub8 = 0, cin8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        rdy8, busy8, done8, cy8, ov8;
    logic [7:0]  sum8;

    logic        start16 = 0, sub16 = 0, cin16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        rdy16, busy16, done16, cy16, ov16;
    logic [15:0] sum16;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_in(start8), .sub_in(sub8),
        .a_in(a8), .b_in(b8), .c_in(cin8), .ready_out(rdy8), .busy_out(busy8),
        .done_out(done8), .sum_out(sum8), .carry_out(cy8), .ovf_out(ov8)
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_in(start16), .sub_in(sub16),
        .a_in(a16), .b_in(b16), .c_in(cin16), .ready_out(rdy16), .busy_out(busy16),
        .done_out(done16), .sum_out(sum16), .carry_out(cy16), .ovf_out(ov16)
    );

    // Launches one operation and waits for done; lat = -1 on timeout
    task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          output logic [15:0] s, output logic cy, output logic ov,
                          output int lat, output int bcnt);
        bit seen;
        @(negedge clk);
        if (w16) begin
            a16 = a; b16 = b; cin16 = cin; sub16 = sub; start16 = 1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; start8 = 1;
        end
        @(posedge clk);
        lat = 0; bcnt = 0; s = 0; cy = 0; ov = 0; seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            lat++;
            start8 = 0; start16 = 0;
            if (w16 ? busy16 : busy8) bcnt++;
            if (w16 ? done16 : done8) begin
                seen = 1;
                s  = w16 ? sum16 : {8'h00, sum8};
                cy = w16 ? cy16 : cy8;
                ov = w16 ? ov16 : ov8;
            end
        end
        if (!seen) lat = -1;
    endtask

    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub,
                                  output logic [15:0] s, output logic cy, output logic ov);
        logic [16:0] full;
        logic [15:0] mask, am, bm;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        am = a & mask;
        bm = b & mask;
        if (!sub) full = {1'b0, am} + {1'b0, bm} + {16'h0, cin};
        else      full = {1'b0, am} - {1'b0, bm};
        s  = full[15:0] & mask;
        cy = sub ? (am >= bm) : full[w];
        if (!sub) ov = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        else      ov = (am[w-1] != bm[w-1]) && (s[w-1] != am[w-1]);
    endfunction

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({sum8, cy8, ov8, done8, busy8, rdy8} !== {8'h00, 5'b00001}) begin
            n_err++;
            $display("FAIL reset_state: got sum=%h c=%b o=%b d=%b b=%b r=%b expected 00 0 0 0 0 1",
                     sum8, cy8, ov8, done8, busy8, rdy8);
        end
        rst_n = 1;
    endtask

    task automatic test_add();
        logic [15:0] s; logic cy, ov; int lat, bc;
        logic [15:0] ta [3] = '{16'h5A, 16'hFF, 16'h7F};
        logic [15:0] tb [3] = '{16'h3C, 16'h01, 16'h00};
        logic        tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0]  es [3] = '{8'h96, 8'h01, 8'h80};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        logic        eo [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(0, ta[i], tb[i], tc[i], 1'b0, s, cy, ov, lat, bc);
            n_cmp++;
            if (lat != 9) begin
                n_err++; $display("FAIL add_latency[%0d]: got %0d expected 9", i, lat);
            end
            n_cmp++;
            if ({s[7:0], cy, ov} !== {es[i], ec[i], eo[i]}) begin
                n_err++;
                $display("FAIL add_result[%0d]: got %h c=%b o=%b expected %h c=%b o=%b",
                         i, s[7:0], cy, ov, es[i], ec[i], eo[i]);
            end
            n_cmp++;
            if (bc != 8) begin
                n_err++; $display("FAIL add_busy_cycles[%0d]: got %0d expected 8", i, bc);
            end
            @(negedge clk);
            n_cmp++;
            if (done8 !== 1'b0 || sum8 !== es[i]) begin
                n_err++;
                $display("FAIL add_done_pulse[%0d]: got done=%b sum=%h expected done=0 sum=%h",
                         i, done8, sum8, es[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [15:0] s; logic cy, ov; int lat, bc;
        run_op(0, 16'h10, 16'h20, 1'b1, 1'b1, s, cy, ov, lat, bc);
        n_cmp++;
        if ({s[7:0], cy, ov} !== {8'hF0, 1'b0, 1'b0} || lat != 9) begin
            n_err++;
            $display("FAIL sub_borrow: got %h c=%b o=%b lat=%0d expected f0 c=0 o=0 lat=9", s[7:0], cy, ov, lat);
        end
        run_op(0, 16'h80, 16'h01, 1'b0, 1'b1, s, cy, ov, lat, bc);
        n_cmp++;
        if ({s[7:0], cy, ov} !== {8'h7F, 1'b1, 1'b1} || lat != 9) begin
            n_err++;
            $display("FAIL sub_ovf: got %h c=%b o=%b lat=%0d expected 7f c=1 o=1 lat=9", s[7:0], cy, ov, lat);
        end
    endtask

    task automatic test_toggle_during_run();
        int lat; bit seen;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 0; sub8 = 0; start8 = 1;
        @(posedge clk);
        lat = 0; seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (done8) begin
                seen = 1;
                start8 = 0;
            end else begin
                start8 = ~start8;
                a8 = 8'($urandom); b8 = 8'($urandom);
                cin8 = 1'($urandom); sub8 = 1'($urandom);
            end
        end
        n_cmp++;
        if (!seen || lat != 9 || {sum8, cy8, ov8} !== {8'h96, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL toggle_run: got seen=%b lat=%0d sum=%h c=%b o=%b expected lat=9 96 c=0 o=1",
                     seen, lat, sum8, cy8, ov8);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; bit first_seen, busy_next, second_seen;
        logic [7:0] s1;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h05; cin8 = 0; sub8 = 0; start8 = 1;
        @(posedge clk);
        lat = 0; first_seen = 0; busy_next = 0; second_seen = 0; s1 = 0;
        for (int k = 0; k < 60 && !second_seen; k++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                a8 = 8'h01; b8 = 8'h02;
            end
            if (lat == 10) begin
                busy_next = busy8;
                start8 = 0;
            end
            if (done8 && !first_seen) begin
                first_seen = 1;
                s1 = sum8;
                n_cmp++;
                if (lat != 9 || rdy8 !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_first_done: got lat=%0d ready=%b expected lat=9 ready=1", lat, rdy8);
                end
            end else if (done8 && first_seen) begin
                second_seen = 1;
            end
        end
        n_cmp++;
        if (s1 !== 8'h15) begin
            n_err++; $display("FAIL b2b_first_sum: got %h expected 15", s1);
        end
        n_cmp++;
        if (!busy_next) begin
            n_err++; $display("FAIL b2b_no_gap: got busy=0 after DONE expected busy=1");
        end
        n_cmp++;
        if (!second_seen || lat != 18 || sum8 !== 8'h03) begin
            n_err++;
            $display("FAIL b2b_second: got seen=%b lat=%0d sum=%h expected lat=18 sum=03", second_seen, lat, sum8);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] s; logic cy, ov; int lat, bc;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 0; sub8 = 0; start8 = 1;
        @(posedge clk);
        @(negedge clk);
        start8 = 0;
        repeat (4) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        n_cmp++;
        if ({sum8, cy8, ov8, done8, busy8, rdy8} !== {8'h00, 5'b00001}) begin
            n_err++;
            $display("FAIL reset_mid: got sum=%h c=%b o=%b d=%b b=%b r=%b expected 00 0 0 0 0 1",
                     sum8, cy8, ov8, done8, busy8, rdy8);
        end
        run_op(0, 16'h01, 16'h01, 1'b0, 1'b0, s, cy, ov, lat, bc);
        n_cmp++;
        if ({s[7:0], cy, ov} !== {8'h02, 1'b0, 1'b0} || lat != 9) begin
            n_err++;
            $display("FAIL after_reset_add: got %h c=%b o=%b lat=%0d expected 02 c=0 o=0 lat=9", s[7:0], cy, ov, lat);
        end
    endtask

    task automatic test_random(input bit w16);
        logic [15:0] s, es, a, b; logic cy, ov, ecy, eov, cin, sub; int lat, bc, w;
        w = w16 ? 16 : 8;
        for (int i = 0; i < 500; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            if (!w16) begin
                a[15:8] = 0; b[15:8] = 0;
            end
            model(w, a, b, cin, sub, es, ecy, eov);
            run_op(w16, a, b, cin, sub, s, cy, ov, lat, bc);
            n_cmp++;
            if ({s, cy, ov} !== {es, ecy, eov} || lat != w + 1 || bc != w) begin
                n_err++;
                $display("FAIL random_w%0d[%0d]: a=%h b=%h cin=%b sub=%b got %h c=%b o=%b lat=%0d busy=%0d expected %h c=%b o=%b lat=%0d busy=%0d",
                         w, i, a, b, cin, sub, s, cy, ov, lat, bc, es, ecy, eov, w + 1, w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_toggle_during_run();
        test_back_to_back();
        test_reset_mid_op();
        test_random(1'b0);
        test_random(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
